// File: rtl/suite_pattern_sequencer.sv
// Keyboard-driven pattern/level/invert selector for the suite renderer.
// Key presses edit shadow settings; the renderer sees them only at each vblank rising edge.
`timescale 1ns/1ps
module suite_pattern_sequencer #(
    parameter int unsigned NUM_PATTERNS = 12,
    parameter int unsigned AUTO_FRAMES  = 300,
    parameter int unsigned LEVEL_MAX    = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        v_blank,
    output logic [3:0]  pattern,
    output logic [3:0]  level,
    output logic        invert,
    output logic        auto_active,
    output logic        commit
);

    typedef enum logic [0:0] {StManual, StAuto} mode_e;

    localparam logic [3:0]  PatLast   = 4'(NUM_PATTERNS - 1);
    localparam logic [3:0]  LvlMax    = 4'(LEVEL_MAX);
    localparam logic [15:0] FrameLast = 16'(AUTO_FRAMES - 1);

    mode_e       mode_q, mode_d;
    logic        armed_q;
    logic        key_tog_q;
    logic        v_blank_q;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  pat_q, pat_d;
    logic [3:0]  lvl_q, lvl_d;
    logic        inv_q, inv_d;
    logic [3:0]  pattern_q, level_q;
    logic        invert_q, commit_q;
    logic        key_event;
    logic        vb_edge;

    // Both detectors are held off until the first post-reset clock has sampled the inputs.
    assign key_event = armed_q && (ps2_key[10] != key_tog_q) && ps2_key[9];
    assign vb_edge   = armed_q && v_blank && !v_blank_q;

    always_comb begin
        mode_d  = mode_q;
        frame_d = frame_q;
        pat_d   = pat_q;
        lvl_d   = lvl_q;
        inv_d   = inv_q;

        if (key_event) begin
            case ({ps2_key[8], ps2_key[7:0]})
                9'h174: begin
                    pat_d  = (pat_q == PatLast) ? 4'd0 : pat_q + 4'd1;
                    mode_d = StManual;
                end
                9'h16B: begin
                    pat_d  = (pat_q == 4'd0) ? PatLast : pat_q - 4'd1;
                    mode_d = StManual;
                end
                9'h175: lvl_d = (lvl_q == LvlMax) ? LvlMax : lvl_q + 4'd1;
                9'h172: lvl_d = (lvl_q == 4'd0) ? 4'd0 : lvl_q - 4'd1;
                9'h029: inv_d = ~inv_q;
                9'h01C: begin
                    if (mode_q == StAuto) begin
                        mode_d = StManual;
                    end else begin
                        mode_d  = StAuto;
                        frame_d = 16'd0;
                    end
                end
                default: ;
            endcase
        end

        // Auto advance only while auto mode persists through this cycle.
        if (vb_edge && mode_q == StAuto && mode_d == StAuto) begin
            if (frame_q == FrameLast) begin
                frame_d = 16'd0;
                pat_d   = (pat_d == PatLast) ? 4'd0 : pat_d + 4'd1;
            end else begin
                frame_d = frame_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= StManual;
            armed_q   <= 1'b0;
            key_tog_q <= 1'b0;
            v_blank_q <= 1'b0;
            frame_q   <= 16'd0;
            pat_q     <= 4'd0;
            lvl_q     <= LvlMax;
            inv_q     <= 1'b0;
            pattern_q <= 4'd0;
            level_q   <= LvlMax;
            invert_q  <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            armed_q   <= 1'b1;
            key_tog_q <= ps2_key[10];
            v_blank_q <= v_blank;
            frame_q   <= frame_d;
            pat_q     <= pat_d;
            lvl_q     <= lvl_d;
            inv_q     <= inv_d;
            commit_q  <= vb_edge;
            if (vb_edge) begin
                pattern_q <= pat_d;
                level_q   <= lvl_d;
                invert_q  <= inv_d;
            end
        end
    end

    assign pattern     = pattern_q;
    assign level       = level_q;
    assign invert      = invert_q;
    assign auto_active = (mode_q == StAuto);
    assign commit      = commit_q;

endmodule

// File: tb/tb_suite_pattern_sequencer.sv
// Directed bench for suite_pattern_sequencer: arm, wrap, deferral, saturation, auto, async reset.
`timescale 1ns/1ps
module tb_suite_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        v_blank;
    logic [3:0]  pattern;
    logic [3:0]  level;
    logic        invert;
    logic        auto_active;
    logic        commit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    suite_pattern_sequencer #(
        .NUM_PATTERNS(12),
        .AUTO_FRAMES (3),
        .LEVEL_MAX   (15)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .v_blank    (v_blank),
        .pattern    (pattern),
        .level      (level),
        .invert     (invert),
        .auto_active(auto_active),
        .commit     (commit)
    );

    // Toggles bit 10; the DUT samples the event at the following posedge.
    task automatic send_key(input logic ext, input logic [7:0] code, input logic press);
        @(posedge clk);
        #1 ps2_key = {~ps2_key[10], press, ext, code};
    endtask

    task automatic do_vblank();
        @(posedge clk);
        #1 v_blank = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (commit !== 1'b1) begin
            bad++;
            $display("FAIL commit_pulse got=%0b want=1", commit);
        end
        @(posedge clk);
        #1;
        total++;
        if (commit !== 1'b0) begin
            bad++;
            $display("FAIL commit_single got=%0b want=0", commit);
        end
        v_blank = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        v_blank = 1'b0;
        ps2_key = {1'b1, 1'b1, 1'b1, 8'h74};
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (pattern !== 4'd0) begin bad++; $display("FAIL rst_pattern got=%0d want=0", pattern); end
        total++;
        if (level !== 4'd15) begin bad++; $display("FAIL rst_level got=%0d want=15", level); end
        total++;
        if (invert !== 1'b0) begin bad++; $display("FAIL rst_invert got=%0b want=0", invert); end
        total++;
        if (auto_active !== 1'b0) begin bad++; $display("FAIL rst_auto got=%0b want=0", auto_active); end
        total++;
        if (commit !== 1'b0) begin bad++; $display("FAIL rst_commit got=%0b want=0", commit); end
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (commit !== 1'b0) begin bad++; $display("FAIL arm_no_commit got=%0b want=0", commit); end
        do_vblank();
        total++;
        if (pattern !== 4'd0) begin bad++; $display("FAIL arm_pattern got=%0d want=0", pattern); end
        total++;
        if (level !== 4'd15) begin bad++; $display("FAIL arm_level got=%0d want=15", level); end
        total++;
        if (invert !== 1'b0) begin bad++; $display("FAIL arm_invert got=%0b want=0", invert); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 13; i++) send_key(1'b1, 8'h74, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (pattern !== 4'd0) begin bad++; $display("FAIL wrap_deferred got=%0d want=0", pattern); end
        do_vblank();
        total++;
        if (pattern !== 4'd1) begin bad++; $display("FAIL wrap_right got=%0d want=1", pattern); end
        for (int i = 0; i < 2; i++) send_key(1'b1, 8'h6B, 1'b1);
        do_vblank();
        total++;
        if (pattern !== 4'd11) begin bad++; $display("FAIL wrap_left got=%0d want=11", pattern); end
    endtask

    task automatic test_level();
        for (int i = 0; i < 20; i++) send_key(1'b1, 8'h75, 1'b1);
        for (int i = 0; i < 3; i++) send_key(1'b1, 8'h72, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (level !== 4'd15) begin bad++; $display("FAIL level_deferred got=%0d want=15", level); end
        do_vblank();
        total++;
        if (level !== 4'd12) begin bad++; $display("FAIL level_sat got=%0d want=12", level); end
        send_key(1'b1, 8'h75, 1'b0);
        send_key(1'b1, 8'h72, 1'b0);
        send_key(1'b1, 8'h74, 1'b0);
        send_key(1'b0, 8'h29, 1'b0);
        do_vblank();
        total++;
        if (level !== 4'd12) begin bad++; $display("FAIL release_level got=%0d want=12", level); end
        total++;
        if (pattern !== 4'd11) begin bad++; $display("FAIL release_pattern got=%0d want=11", pattern); end
        total++;
        if (invert !== 1'b0) begin bad++; $display("FAIL release_invert got=%0b want=0", invert); end
    endtask

    task automatic test_simultaneous();
        @(posedge clk);
        #1;
        v_blank = 1'b1;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h29};
        @(posedge clk);
        #1;
        total++;
        if (commit !== 1'b1) begin bad++; $display("FAIL simul_commit got=%0b want=1", commit); end
        total++;
        if (invert !== 1'b1) begin bad++; $display("FAIL simul_invert got=%0b want=1", invert); end
        @(posedge clk);
        #1 v_blank = 1'b0;
    endtask

    task automatic test_auto();
        logic [3:0] exp_pat [6];
        exp_pat = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        send_key(1'b1, 8'h74, 1'b1);
        do_vblank();
        total++;
        if (pattern !== 4'd0) begin bad++; $display("FAIL auto_start got=%0d want=0", pattern); end
        send_key(1'b0, 8'h1C, 1'b1);
        total++;
        if (auto_active !== 1'b0) begin bad++; $display("FAIL auto_early got=%0b want=0", auto_active); end
        @(posedge clk);
        #1;
        total++;
        if (auto_active !== 1'b1) begin bad++; $display("FAIL auto_on got=%0b want=1", auto_active); end
        for (int i = 0; i < 6; i++) begin
            do_vblank();
            total++;
            if (pattern !== exp_pat[i]) begin
                bad++;
                $display("FAIL auto_step%0d got=%0d want=%0d", i + 1, pattern, exp_pat[i]);
            end
        end
        total++;
        if (level !== 4'd12 || invert !== 1'b1) begin
            bad++;
            $display("FAIL auto_keep got=%0d/%0b want=12/1", level, invert);
        end
        send_key(1'b1, 8'h6B, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (auto_active !== 1'b0) begin bad++; $display("FAIL auto_off got=%0b want=0", auto_active); end
        do_vblank();
        total++;
        if (pattern !== 4'd1) begin bad++; $display("FAIL auto_left got=%0d want=1", pattern); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send_key(1'b1, 8'h74, 1'b1);
        do_vblank();
        total++;
        if (pattern !== 4'd5) begin bad++; $display("FAIL mid_setup got=%0d want=5", pattern); end
        send_key(1'b0, 8'h1C, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (auto_active !== 1'b1) begin bad++; $display("FAIL mid_auto got=%0b want=1", auto_active); end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        total++;
        if (pattern !== 4'd0) begin bad++; $display("FAIL async_pattern got=%0d want=0", pattern); end
        total++;
        if (level !== 4'd15) begin bad++; $display("FAIL async_level got=%0d want=15", level); end
        total++;
        if (invert !== 1'b0) begin bad++; $display("FAIL async_invert got=%0b want=0", invert); end
        total++;
        if (auto_active !== 1'b0) begin bad++; $display("FAIL async_auto got=%0b want=0", auto_active); end
        #9 reset_n = 1'b1;
        do_vblank();
        total++;
        if (pattern !== 4'd0) begin bad++; $display("FAIL post_rst_pattern got=%0d want=0", pattern); end
        total++;
        if (level !== 4'd15) begin bad++; $display("FAIL post_rst_level got=%0d want=15", level); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_level();
        test_simultaneous();
        test_auto();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/suite_pattern_sequencer.md
# suite_pattern_sequencer

Keyboard-driven controller that selects which test pattern the `suite` renderer draws, and with what brightness level and inversion. It sits between `hps_io` (`ps2_key`) and `suite`. It decodes PS/2 key events into a set of shadow settings. The shadow settings are committed to the renderer only at the start of vertical blank, so a pattern never changes mid-frame. An auto-cycle mode advances the pattern every N frames for unattended soak runs.

## Interface
Parameters:
- `NUM_PATTERNS`, default 12: number of selectable patterns. Legal range 2..16.
- `AUTO_FRAMES`, default 300: frames per pattern in auto mode. Legal range 1..65535.
- `LEVEL_MAX`, default 15: maximum brightness level. Legal range 1..15.

Ports:
- `clk` in 1: system clock. Same domain as `suite` (`clk_sys`).
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: hps_io key event. [10] toggles once per event, [9] = 1 for press, [8] = extended (E0) prefix, [7:0] = scancode.
- `v_blank` in 1: vertical blank from `suite`, level signal.
- `pattern` out 4: active pattern index, always < `NUM_PATTERNS`.
- `level` out 4: active brightness level, 0..`LEVEL_MAX`.
- `invert` out 1: active colour-inversion flag.
- `auto_active` out 1: auto-cycle mode is on. Takes effect immediately and is not deferred to vblank.
- `commit` out 1: one-cycle pulse when the active outputs are reloaded.

## Operation
- Event detect: a registered copy of `ps2_key[10]` is kept. An event occurs when the live bit differs from the registered copy. Only events with [9] = 1 are acted on; release events are ignored.
- Arm: the first clock after `reset_n` deasserts only captures `ps2_key[10]` and produces no event. This prevents a spurious event when the toggle is 1 at reset.
- Key map for press events. The extended flag must match exactly.
  - E0 74 (right): shadow pattern +1, wrapping `NUM_PATTERNS`-1 → 0. Clears auto mode.
  - E0 6B (left): shadow pattern −1, wrapping 0 → `NUM_PATTERNS`-1. Clears auto mode.
  - E0 75 (up): shadow level +1, saturating at `LEVEL_MAX`.
  - E0 72 (down): shadow level −1, saturating at 0.
  - 29 (space, not extended): toggle shadow invert.
  - 1C ('A', not extended): toggle auto mode. Entering auto mode clears the frame counter.
  - Any other scancode: no effect.
- Mode FSM has two states.
  - MANUAL → AUTO on 'A'.
  - AUTO → MANUAL on 'A', left or right.
  - Reset state is MANUAL.
- Vblank edge: `v_blank` is registered once. The edge condition is `v_blank` & ~`v_blank_q`.
- Frame counter: 16 bits, advances only in AUTO on a vblank edge.
  - If the counter equals `AUTO_FRAMES`-1 on an edge, it returns to 0 and the shadow pattern advances with wrap.
  - Otherwise it increments.
- Commit: on every vblank edge, `pattern`/`level`/`invert` load from the shadow values and `commit` pulses.
  - The loaded values are the shadow values after any same-cycle key update or auto advance is applied. No event is lost or deferred an extra frame.
- Shadow registers reset to pattern 0, level `LEVEL_MAX`, invert 0.

## Timing
- Reset values: `pattern` = 0, `level` = `LEVEL_MAX`, `invert` = 0, `auto_active` = 0, `commit` = 0. The frame counter, the shadow registers and `v_blank_q` all clear.
- Key latency:
  - Shadow updates on the clock edge that samples the toggle change.
  - `auto_active` changes on that same edge.
- Commit latency: outputs and `commit` change on the clock edge that first samples `v_blank` = 1 while `v_blank_q` = 0, i.e. one cycle after `v_blank` rises.
- `commit` is high exactly one cycle per vblank edge. A `v_blank` held high produces no further commits.
- Events arrive at most once per cycle. Back-to-back events in consecutive cycles are each applied.
- `reset_n` asserted mid-frame forces all outputs to their reset values immediately, without waiting for the clock. No commit occurs until the next full vblank rising edge after release.

## Test plan
- Reset/arm: hold `ps2_key[10]` = 1 through reset release, no other activity → no shadow change. First vblank → `commit` pulse with pattern 0, level 15, invert 0.
- Wrap: with NUM_PATTERNS = 12, send 13 right presses then a vblank → `pattern` = 1. Then send 2 left presses and a vblank → `pattern` = 11.
- Deferral and saturation:
  - 20 up presses, then 3 down presses, all mid-frame → `level` stays at its old value until the vblank edge, then `level` = 12.
  - Release events (bit [9] = 0) with the same scancodes → no change.
- Simultaneous: a space press on the same cycle as the vblank edge → `invert` = 1 on that commit, with no one-frame lag.
- Auto: AUTO_FRAMES = 3, press 'A' → `auto_active` = 1 next cycle, and `pattern` steps 0 → 1 on the 3rd vblank edge and 1 → 2 on the 6th. Then a left press → `auto_active` = 0, and the next vblank commits pattern 1.
- Reset mid-operation: with `pattern` = 5 and auto on, pulse `reset_n` low for 1 cycle mid-frame → all outputs return to reset values asynchronously. The next vblank commits pattern 0.
